serial_parallel_gen: RTL and testbench
======================================

Name: serial_parallel_gen

Overview:
- Parametrised serial-to-parallel deserialiser with bit-level comma alignment and a sync qualification state machine.
- Receives a 1-bit stream at the fast clock (clk_32f) and emits WIDTH-bit words with a one-cycle valid strobe.
- Sits on the receive side of the link, after the serial line and before the word-level unstriping logic.
- Generalises the fixed 8-bit converter:
  - configurable word width, comma value and sync count;
  - alignment at any bit offset;
  - comma words dropped from the data path after lock.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
COMMA, 8'hBC (WIDTH bits), alignment/idle symbol
SYNC_COUNT, 4, consecutive aligned commas required to lock; legal range >=1

Ports:
clk_32f  input  1  bit clock; one serial bit sampled per rising edge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial data bit
data_out  output  WIDTH  last accepted word; holds between updates
valid_out  output  1  one-cycle strobe: data_out updated this cycle with a non-comma word
active  output  1  high while locked (state ACTIVE)

Behaviour:
- Reset (sampled at a rising edge, highest priority, also mid-word or mid-sync):
  - outputs: data_out=0, valid_out=0, active=0;
  - internal: shift register=0, bit_cnt=0, comma_cnt=0, state=SEARCH.
- Shift path:
  - every non-reset edge: sr <= {sr[WIDTH-2:0], data_in}; MSB first;
  - nxt = {sr[WIDTH-2:0], data_in} is the word seen on that edge.
- State SEARCH:
  - each edge: if nxt==COMMA, then bit_cnt<=0 and comma_cnt<=1;
  - then go to ACTIVE if SYNC_COUNT==1, else go to WAIT_SYNC.
- State WAIT_SYNC:
  - bit_cnt increments mod WIDTH; a word boundary is the edge with bit_cnt==WIDTH-1;
  - at a boundary with nxt==COMMA: comma_cnt++; on reaching SYNC_COUNT go to ACTIVE;
  - at a boundary with nxt!=COMMA: go to SEARCH, comma_cnt<=0;
  - a comma straddling a non-boundary offset is ignored in WAIT_SYNC.
- State ACTIVE:
  - active=1 and bit_cnt continues mod WIDTH;
  - at each boundary, if nxt!=COMMA: data_out<=nxt, valid_out<=1;
  - at each boundary, if nxt==COMMA: valid_out<=0 and data_out holds (comma dropped);
  - all other cycles: valid_out=0.
- Latency and ordering:
  - valid_out is high in the cycle after the edge sampling a word's last bit;
  - the comma that completes sync is never output; the first candidate data word is the next WIDTH bits.
- Lock persistence: ACTIVE stays locked until reset; there is no loss-of-sync exit.
- Registers: all outputs are registered; there are no combinational paths from data_in to outputs.

Optional Feature:
- Macro SP_LSB_FIRST_EN.
- Defined: shift becomes sr <= {data_in, sr[WIDTH-1:1]}, so the first received bit lands in bit 0. Comma matching uses this same ordering.
- Undefined: MSB-first as in Behaviour.
- State machine, latency and port list are identical in both builds.

Test Plan:
- Reset held 3 cycles with data_in toggling -> data_out=0, valid_out=0, active=0 throughout. Still SEARCH afterwards (no lock on garbage).
- 3 random bits, then 4x 0xBC, then 0xA5 MSB-first -> active rises at the boundary of the 4th comma. Then a single valid_out pulse with data_out=0xA5, one cycle after the edge sampling the last bit of 0xA5.
- 3x 0xBC, then 0x00, then 4x 0xBC, then 0x3C -> no lock after the first group (return to SEARCH). Lock after the second group; one valid pulse with 0x3C.
- Locked, stream 0x11, 0xBC, 0x22 -> valid pulses carry 0x11 and 0x22, with no pulse in the comma word slot. data_out holds 0x11 during the comma slot.
- Locked, reset asserted mid-word for 1 cycle -> next cycle active=0, valid_out=0, data_out=0. Relock requires a full SYNC_COUNT comma sequence.
- WIDTH=10, COMMA=10'h17C, SYNC_COUNT=2, SP_LSB_FIRST_EN defined:
  - stimulus: 2 commas then 10'h2A5, sent LSB-first;
  - expected: data_out=10'h2A5 with a single valid pulse.

Source files
------------

// File: rtl/serial_parallel_gen_if.sv
// serial_parallel_gen_if: bundles the serial input and the word-level outputs of the deserialiser
//   data_in   - serial bit, one per clk_32f rising edge
//   data_out  - last accepted WIDTH-bit word
//   valid_out - one-cycle strobe when data_out takes a new non-comma word
//   active    - high while locked
//   master: deserialiser side; slave: line driver / word consumer side
interface serial_parallel_gen_if #(
    parameter int WIDTH = 8
);
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             active;
    modport master (input data_in, output data_out, valid_out, active);
    modport slave (output data_in, input data_out, valid_out, active);
endinterface

// File: rtl/serial_parallel_gen.sv
// serial_parallel_gen: serial-to-parallel deserialiser with comma alignment and sync qualification
//   clk_32f - bit clock, one serial bit per rising edge
//   reset   - synchronous active-high reset
//   bus     - serial_parallel_gen_if.master (data_in, data_out, valid_out, active)
//   SP_LSB_FIRST_EN - when defined, the first received bit of a word lands in bit 0
module serial_parallel_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
    parameter int               SYNC_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_parallel_gen_if.master bus
);
    localparam int               CW   = $clog2(WIDTH);
    localparam int               KW   = $clog2(SYNC_COUNT + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [KW-1:0]    SYNC = KW'(SYNC_COUNT);

    typedef enum logic [1:0] {SEARCH, WAIT_SYNC, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, nxt, data_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [KW-1:0]    comma_cnt, comma_cnt_nxt;
    logic             valid_nxt, boundary, is_comma;

    // nxt is the word formed by the bit sampled on this edge
`ifdef SP_LSB_FIRST_EN
    assign nxt = {bus.data_in, sr[WIDTH-1:1]};
`else
    assign nxt = {sr[WIDTH-2:0], bus.data_in};
`endif
    assign is_comma  = nxt == COMMA;
    assign boundary  = bit_cnt == LAST;
    assign bus.active = state == ACTIVE;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state         <= SEARCH;
            sr            <= '0;
            bit_cnt       <= '0;
            comma_cnt     <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            state         <= state_nxt;
            sr            <= nxt;
            bit_cnt       <= bit_cnt_nxt;
            comma_cnt     <= comma_cnt_nxt;
            bus.data_out  <= data_nxt;
            bus.valid_out <= valid_nxt;
        end
    end

    // SEARCH hunts for a comma at any bit offset and restarts word framing on it;
    // afterwards only commas landing exactly on a word boundary count.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        data_nxt      = bus.data_out;
        valid_nxt     = 1'b0;
        if (state == SEARCH) begin
            if (is_comma) begin
                bit_cnt_nxt   = '0;
                comma_cnt_nxt = KW'(1);
                state_nxt     = (SYNC_COUNT == 1) ? ACTIVE : WAIT_SYNC;
            end
        end else begin
            bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
            if (boundary && state == WAIT_SYNC) begin
                comma_cnt_nxt = is_comma ? comma_cnt + 1'b1 : '0;
                state_nxt     = !is_comma ? SEARCH :
                                (comma_cnt + 1'b1 == SYNC) ? ACTIVE : WAIT_SYNC;
            end
            if (boundary && state == ACTIVE && !is_comma) begin
                data_nxt  = nxt;
                valid_nxt = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_parallel_gen.sv
// tb_serial_parallel_gen: directed stimulus with a queue scoreboard checked by a valid_out monitor
module tb_serial_parallel_gen;
`ifdef SP_LSB_FIRST_EN
    localparam int           W = 10;
    localparam logic [W-1:0] C = 10'h17C;
    localparam int           S = 2;
`else
    localparam int           W = 8;
    localparam logic [W-1:0] C = 8'hBC;
    localparam int           S = 4;
`endif

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_32f = ~clk_32f;

    serial_parallel_gen_if #(.WIDTH(W)) bus ();
    serial_parallel_gen #(.WIDTH(W), .COMMA(C), .SYNC_COUNT(S)) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int           at;
        logic [W-1:0] w;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk_32f) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_data"}, bus.data_out, '0);
        chk({name, "_valid"}, W'(bus.valid_out), '0);
        chk({name, "_active"}, W'(bus.active), '0);
    endtask

    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // the valid strobe for a word is expected in the cycle right after its last bit's edge
    task automatic send_word(input logic [W-1:0] w, input bit expect_out);
        for (int i = 0; i < W; i++) begin
`ifdef SP_LSB_FIRST_EN
            send_bit(w[i]);
`else
            send_bit(w[W-1-i]);
`endif
        end
        if (expect_out) sb.push_back('{cyc, w});
    endtask

    always @(negedge clk_32f) begin
        exp_t e;
        if (bus.valid_out !== 1'b0) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got data_out %0h valid %b at cycle %0d, expected no strobe",
                         bus.data_out, bus.valid_out, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.data_out !== e.w || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL word: got %0h at cycle %0d, expected %0h at cycle %0d",
                             bus.data_out, cyc, e.w, e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.data_in = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(i[0]);
            chk_idle("reset");
        end
        reset = 1'b0;
`ifdef SP_LSB_FIRST_EN
        send_word(C, 0);
        chk("no_lock_early", W'(bus.active), '0);
        send_word(C, 0);
        chk("lock", W'(bus.active), W'(1));
        send_word(10'h2A5, 1);
        send_word(10'h011, 1);
        send_word(C, 0);
        chk("comma_hold", bus.data_out, 10'h011);
        chk("comma_no_valid", W'(bus.valid_out), '0);
        send_word(10'h022, 1);
`else
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("search_after_garbage", W'(bus.active), '0);
        repeat (S - 1) send_word(C, 0);
        chk("no_lock_early", W'(bus.active), '0);
        send_word(C, 0);
        chk("lock", W'(bus.active), W'(1));
        chk("lock_comma_dropped", W'(bus.valid_out), '0);
        send_word(8'hA5, 1);
        send_word(8'h11, 1);
        send_word(C, 0);
        chk("comma_hold", bus.data_out, 8'h11);
        chk("comma_no_valid", W'(bus.valid_out), '0);
        send_word(8'h22, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        chk_idle("mid_reset");
        repeat (3) send_word(C, 0);
        send_word(8'h00, 0);
        chk("break_no_lock", W'(bus.active), '0);
        repeat (S - 1) send_word(C, 0);
        chk("relock_early", W'(bus.active), '0);
        send_word(C, 0);
        chk("relock", W'(bus.active), W'(1));
        send_word(8'h3C, 1);
`endif
        repeat (4) send_bit(1'b0);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_word: got no strobe, expected %0h at cycle %0d", e.w, e.at);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
